// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master issuing single-register ADXL362 read/write frames
// (command, address, data) and returning the byte captured on reads.
module adxl362_spi_master #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk_16mhz,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [5:0] address,
    input  logic [7:0] data_write,
    output logic [7:0] data_read,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    localparam int HALF_W = $clog2(CLK_DIV);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'd23;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

    state_t            state_reg, state_next;
    logic [HALF_W-1:0] half_reg, half_next;
    logic [4:0]        bit_reg, bit_next;
    logic [23:0]       tx_reg, tx_next;
    logic [7:0]        rx_reg, rx_next;
    logic              rw_reg, rw_next;
    logic [7:0]        data_read_reg, data_read_next;
    logic              done_reg, done_next;

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            state_reg     <= IDLE;
            half_reg      <= '0;
            bit_reg       <= '0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            rw_reg        <= 1'b0;
            data_read_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            half_reg      <= half_next;
            bit_reg       <= bit_next;
            tx_reg        <= tx_next;
            rx_reg        <= rx_next;
            rw_reg        <= rw_next;
            data_read_reg <= data_read_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        half_next      = half_reg;
        bit_next       = bit_reg;
        tx_next        = tx_reg;
        rx_next        = rx_reg;
        rw_next        = rw_reg;
        data_read_next = data_read_reg;
        done_next      = 1'b0;

        if (state_reg == IDLE) begin
            if (start) begin
                state_next = SETUP;
                half_next  = '0;
                bit_next   = '0;
                rw_next    = rw;
                tx_next    = {(rw ? 8'h0B : 8'h0A), 2'b00, address,
                              (rw ? 8'h00 : data_write)};
            end
        end else if (half_reg != HALF_LAST) begin
            half_next = half_reg + 1'b1;
        end else begin
            half_next = '0;
            // Each phase ends here; rising sclk samples miso, falling sclk shifts mosi.
            case (state_reg)
                SETUP: begin
                    state_next = SHIFT_HI;
                    rx_next    = {rx_reg[6:0], miso};
                end
                SHIFT_HI: begin
                    state_next = SHIFT_LO;
                    tx_next    = {tx_reg[22:0], 1'b0};
                end
                SHIFT_LO: begin
                    if (bit_reg == LAST_BIT) begin
                        state_next = GAP;
                        done_next  = 1'b1;
                        if (rw_reg) begin
                            data_read_next = rx_reg;
                        end
                    end else begin
                        state_next = SHIFT_HI;
                        bit_next   = bit_reg + 5'd1;
                        rx_next    = {rx_reg[6:0], miso};
                    end
                end
                GAP:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign cs_n      = (state_reg == IDLE) || (state_reg == GAP);
    assign sclk      = (state_reg == SHIFT_HI);
    assign busy      = (state_reg != IDLE);
    assign mosi      = (state_reg == SETUP || state_reg == SHIFT_HI || state_reg == SHIFT_LO)
                       ? tx_reg[23] : 1'b0;
    assign done      = done_reg;
    assign data_read = data_read_reg;
endmodule

// File: tb/tb_adxl362_spi_master.sv
// Bench for adxl362_spi_master: ADXL362 register model on the SPI pins plus
// an expected-register array, directed and random single-register frames.
module tb_adxl362_spi_master;
    localparam int CD  = 8;
    localparam int CDB = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, rw_a = 1'b0, miso_a;
    logic [5:0] address_a = '0;
    logic [7:0] data_write_a = '0, data_read_a;
    logic       busy_a, done_a, cs_n_a, sclk_a, mosi_a;

    logic       start_b = 1'b0, rw_b = 1'b0, miso_b = 1'b1;
    logic [5:0] address_b = '0;
    logic [7:0] data_write_b = '0, data_read_b;
    logic       busy_b, done_b, cs_n_b, sclk_b, mosi_b;

    int total = 0;
    int bad = 0;

    adxl362_spi_master #(.CLK_DIV(CD)) dut_a (
        .clk_16mhz(clk), .reset(reset), .start(start_a), .rw(rw_a),
        .address(address_a), .data_write(data_write_a), .data_read(data_read_a),
        .busy(busy_a), .done(done_a), .cs_n(cs_n_a), .sclk(sclk_a),
        .mosi(mosi_a), .miso(miso_a));

    adxl362_spi_master #(.CLK_DIV(CDB)) dut_b (
        .clk_16mhz(clk), .reset(reset), .start(start_b), .rw(rw_b),
        .address(address_b), .data_write(data_write_b), .data_read(data_read_b),
        .busy(busy_b), .done(done_b), .cs_n(cs_n_b), .sclk(sclk_b),
        .mosi(mosi_b), .miso(miso_b));

    initial forever #5 clk = ~clk;

    // Free-running monitors; tasks work from snapshot differences.
    int cyc = 0, cs_low_a = 0, done_cnt_a = 0, rises_a = 0, rises_b = 0;
    logic [23:0] mon_frame = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs_n_a === 1'b0) cs_low_a <= cs_low_a + 1;
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end
    always @(posedge sclk_a) begin
        rises_a   <= rises_a + 1;
        mon_frame <= {mon_frame[22:0], mosi_a};
    end
    always @(posedge sclk_b) rises_b <= rises_b + 1;

    // Behavioural ADXL362: drives miso on falling sclk, writes on the 24th bit.
    logic [7:0] dev_mem [64];
    initial begin : dev_model
        int dev_bits;
        logic [23:0] dev_sh;
        logic [7:0] dev_cmd;
        logic [5:0] dev_addr;
        logic prev_cs, prev_sclk;
        for (int i = 0; i < 64; i++) dev_mem[i] = 8'h00;
        dev_mem[0] = 8'hAD; dev_mem[1] = 8'h1D; dev_mem[2] = 8'hF2; dev_mem[3] = 8'h01;
        miso_a = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b0;
        dev_bits = 0; dev_sh = '0; dev_cmd = '0; dev_addr = '0;
        forever begin
            @(cs_n_a or sclk_a);
            if (prev_cs && !cs_n_a) begin
                dev_bits = 0;
                miso_a = 1'($urandom);
            end else if (!cs_n_a && !prev_sclk && sclk_a) begin
                dev_sh = {dev_sh[22:0], mosi_a};
                dev_bits++;
                if (dev_bits == 16) begin
                    dev_cmd = dev_sh[15:8];
                    dev_addr = dev_sh[5:0];
                end
                if (dev_bits == 24 && dev_sh[23:16] == 8'h0A) dev_mem[dev_sh[13:8]] = dev_sh[7:0];
            end else if (!cs_n_a && prev_sclk && !sclk_a && dev_bits < 24) begin
                if (dev_bits >= 16 && dev_cmd == 8'h0B) miso_a = dev_mem[dev_addr][23 - dev_bits];
                else miso_a = 1'($urandom);
            end
            prev_cs = cs_n_a;
            prev_sclk = sclk_a;
        end
    end

    // Expected register contents and expected data_read.
    logic [7:0] exp_mem [64];
    logic [7:0] exp_dr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on DUT A; poke re-pulses start at N+50 and N+395, which must be ignored.
    task automatic xfer(input logic r, input logic [5:0] a, input logic [7:0] d, input logic poke);
        int n, c, t, d_at, b_cs, b_rise, b_done;
        logic [23:0] fr;
        logic [7:0] exp_after;
        fr = {(r ? 8'h0B : 8'h0A), 2'b00, a, (r ? 8'h00 : d)};
        exp_after = r ? exp_mem[a] : exp_dr;
        t = 0;
        while (busy_a !== 1'b0 && t < 1000) begin tick(); t++; end
        check("idle_before", 32'(busy_a), 32'd0);
        b_cs = cs_low_a; b_rise = rises_a; b_done = done_cnt_a;
        start_a = 1'b1; rw_a = r; address_a = a; data_write_a = d;
        tick();
        n = cyc;
        start_a = 1'b0; rw_a = 1'($urandom); address_a = 6'($urandom); data_write_a = 8'($urandom);
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_csn", 32'(cs_n_a), 32'd0);
        check("start_mosi", 32'(mosi_a), 32'(fr[23]));
        d_at = -1;
        for (int i = 0; i < 50 * CD; i++) begin
            tick();
            c = cyc - n;
            if (poke) start_a = (c == 49 || c == 394);
            if (done_a === 1'b1 && d_at < 0) d_at = c;
            if (c == CD - 1) check("pre_rise_sclk", 32'(sclk_a), 32'd0);
            if (c == CD) check("first_rise_sclk", 32'(sclk_a), 32'd1);
            if (c == 48 * CD) check("mosi_after_last_fall", 32'(mosi_a), 32'd0);
            if (c == 49 * CD) begin
                check("end_csn", 32'(cs_n_a), 32'd1);
                check("end_sclk", 32'(sclk_a), 32'd0);
                check("end_done", 32'(done_a), 32'd1);
                check("data_read", 32'(data_read_a), 32'(exp_after));
            end
            if (c == 49 * CD + 1) check("done_one_cycle", 32'(done_a), 32'd0);
            if (c == 50 * CD - 1) check("gap_busy", 32'(busy_a), 32'd1);
            if (c == 50 * CD) check("idle_busy", 32'(busy_a), 32'd0);
        end
        start_a = 1'b0;
        tick();
        check("no_queued_start", 32'(busy_a), 32'd0);
        check("done_cycle", 32'(d_at), 32'(49 * CD));
        check("sclk_rises", 32'(rises_a - b_rise), 32'd24);
        check("mosi_frame", 32'(mon_frame), 32'(fr));
        check("cs_low_cycles", 32'(cs_low_a - b_cs), 32'(49 * CD));
        check("done_count", 32'(done_cnt_a - b_done), 32'd1);
        if (r) exp_dr = exp_mem[a];
        else exp_mem[a] = d;
        $display("xfer %s addr=%02h wdata=%02h rdata=%02h poke=%0d", r ? "RD" : "WR", a, d, data_read_a, poke);
    endtask

    initial begin : main
        int n, c, b_rise, b_done;
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
        exp_mem[0] = 8'hAD; exp_mem[1] = 8'h1D; exp_mem[2] = 8'hF2; exp_mem[3] = 8'h01;
        exp_dr = 8'h00;

        // Reset with start held high: reset wins.
        reset = 1'b1; start_a = 1'b1;
        tick(); tick();
        check("rst_csn", 32'(cs_n_a), 32'd1);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_data_read", 32'(data_read_a), 32'd0);
        reset = 1'b0; start_a = 1'b0;
        b_rise = rises_a;
        for (int i = 0; i < 100; i++) tick();
        check("rst_no_sclk", 32'(rises_a - b_rise), 32'd0);
        check("rst_idle_busy", 32'(busy_a), 32'd0);
        $display("reset sequence checked");

        xfer(1'b0, 6'h20, 8'h55, 1'b0);
        check("model_thresh_act_l", 32'(dev_mem[6'h20]), 32'h55);
        xfer(1'b1, 6'h20, 8'h00, 1'b0);
        xfer(1'b1, 6'h00, 8'h00, 1'b1);
        xfer(1'b1, 6'h02, 8'h00, 1'b0);

        // Reset at N+200 of a read aborts it.
        b_done = done_cnt_a;
        start_a = 1'b1; rw_a = 1'b1; address_a = 6'h01;
        tick();
        n = cyc;
        start_a = 1'b0;
        for (int i = 0; i < 260; i++) begin
            tick();
            c = cyc - n;
            reset = (c == 199);
            if (c == 200) begin
                check("abort_csn", 32'(cs_n_a), 32'd1);
                check("abort_busy", 32'(busy_a), 32'd0);
                check("abort_data_read", 32'(data_read_a), 32'd0);
                check("abort_done", 32'(done_a), 32'd0);
            end
        end
        reset = 1'b0;
        check("abort_no_done", 32'(done_cnt_a - b_done), 32'd0);
        exp_dr = 8'h00;
        $display("abort read at N+200 data_read=%02h", data_read_a);
        xfer(1'b1, 6'h02, 8'h00, 1'b0);

        // CLK_DIV=2 instance: done at N+98, busy low at N+100.
        b_rise = rises_b;
        start_b = 1'b1; rw_b = 1'b1; address_b = 6'($urandom);
        tick();
        n = cyc;
        start_b = 1'b0;
        for (int i = 0; i < 50 * CDB; i++) begin
            tick();
            c = cyc - n;
            if (c == 49 * CDB - 1) check("b_pre_done", 32'(done_b), 32'd0);
            if (c == 49 * CDB) begin
                check("b_done", 32'(done_b), 32'd1);
                check("b_data_read", 32'(data_read_b), 32'hFF);
            end
            if (c == 50 * CDB - 1) check("b_gap_busy", 32'(busy_b), 32'd1);
            if (c == 50 * CDB) check("b_idle_busy", 32'(busy_b), 32'd0);
        end
        check("b_sclk_rises", 32'(rises_b - b_rise), 32'd24);
        $display("clk_div2 read data_read=%02h", data_read_b);

        for (int k = 0; k < 8; k++) begin
            xfer(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
